// File: rtl/ipa_ctx_pkg.sv
// Shared constants, address-field layout and word-type encoding for the
// CGRA context unpacker.
package ipa_ctx_pkg;

  localparam int INST_W      = 20;
  localparam int LANES       = 4;
  localparam int ROW_W       = LANES * INST_W;
  localparam int WORD_W      = 64;
  localparam int ACC_W       = 144;
  localparam int FILL_W      = 7;

  localparam int ADDR_W      = 23;
  localparam int MASK_LSB    = 0;
  localparam int MASK_W      = 16;
  localparam int TYPE_BIT    = 16;
  localparam int IDX_LSB     = 17;
  localparam int IDX_W       = 6;
  localparam int CONST_IDX_W = 4;
  localparam int ROW_ADDR_W  = 5;

  typedef enum logic {
    WORD_INST  = 1'b0,
    WORD_CONST = 1'b1
  } word_type_e;

  // Lanes that hold a complete instruction when `fill` bits are buffered.
  function automatic logic [LANES-1:0] lanes_from_fill(input logic [FILL_W-1:0] fill,
                                                       input int lane_w);
    lanes_from_fill = '0;
    for (int k = 0; k < LANES; k++) begin
      if (int'(fill) >= (k + 1) * lane_w) lanes_from_fill[k] = 1'b1;
    end
  endfunction

endpackage

// File: rtl/ipa_bit_gearbox.sv
// 64-bit to 80-bit gearbox: appends words LSB-first into a 144-bit
// accumulator, offers full or partial rows, and shifts leftovers down.
module ipa_bit_gearbox
  import ipa_ctx_pkg::*;
#(
  parameter int LANE_W = INST_W
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              push_i,
  input  logic [WORD_W-1:0] word_i,
  input  logic              flush_i,
  output logic              emit_o,
  output logic [ROW_W-1:0]  row_o,
  output logic [LANES-1:0]  lanes_o
);

  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic [ACC_W-1:0]  base_acc;
  logic [ACC_W-1:0]  appended;
  logic [7:0]        base_fill;
  logic [7:0]        sum;

  // A flush drains the old contents; a word pushed in the same cycle lands
  // in a fresh accumulator, so at most one row leaves per cycle.
  always_comb begin
    base_acc  = flush_i ? '0 : acc_q;
    base_fill = flush_i ? 8'd0 : {1'b0, fill_q};
    appended  = base_acc | ({{(ACC_W-WORD_W){1'b0}}, word_i} << base_fill);
    sum       = base_fill + 8'(WORD_W);
    acc_d     = acc_q;
    fill_d    = fill_q;
    emit_o    = 1'b0;
    row_o     = '0;
    lanes_o   = '0;
    if (flush_i) begin
      emit_o  = (fill_q >= FILL_W'(LANE_W));
      row_o   = acc_q[ROW_W-1:0];
      lanes_o = lanes_from_fill(fill_q, LANE_W);
      acc_d   = '0;
      fill_d  = '0;
    end
    if (push_i) begin
      if (!flush_i && (sum >= 8'(ROW_W))) begin
        emit_o  = 1'b1;
        row_o   = appended[ROW_W-1:0];
        lanes_o = '1;
        acc_d   = appended >> ROW_W;
        fill_d  = FILL_W'(sum - 8'(ROW_W));
      end else begin
        acc_d   = appended;
        fill_d  = sum[FILL_W-1:0];
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      acc_q  <= '0;
      fill_q <= '0;
    end else begin
      acc_q  <= acc_d;
      fill_q <= fill_d;
    end
  end

endmodule

// File: rtl/ipa_ctx_unpacker.sv
// Context-load unpacker: routes DMA context words into per-tile instruction
// rows and constant writes, tracking the active tile and row overflow.
module ipa_ctx_unpacker
  import ipa_ctx_pkg::*;
#(
  parameter int NB_TILES  = 16,
  parameter int INST_W    = 20,
  parameter int ROW_DEPTH = 32
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   wr_en_i,
  input  logic [ADDR_W-1:0]      addr_i,
  input  logic [WORD_W-1:0]      data_i,
  input  logic                   flush_i,
  output logic [NB_TILES-1:0]    inst_we_o,
  output logic [ROW_ADDR_W-1:0]  inst_addr_o,
  output logic [ROW_W-1:0]       inst_data_o,
  output logic [LANES-1:0]       inst_lane_vld_o,
  output logic [NB_TILES-1:0]    const_we_o,
  output logic [CONST_IDX_W-1:0] const_addr_o,
  output logic [WORD_W-1:0]      const_data_o,
  output logic                   ovf_o,
  output logic                   exec_en_o
);

  localparam int RC_W = $clog2(ROW_DEPTH + 1);

  word_type_e          wtype;
  logic [NB_TILES-1:0] word_mask;
  logic                is_inst, is_const, push, tile_active, flush_evt;
  logic                g_emit, row_full, write_ok;
  logic [ROW_W-1:0]    g_row;
  logic [LANES-1:0]    g_lanes;
  logic                unused_idx_hi;

  logic [NB_TILES-1:0]    mask_q, mask_d;
  logic [RC_W-1:0]        row_q, row_d;
  logic                   ovf_q, ovf_d;
  logic                   exec_q, exec_d;
  logic [NB_TILES-1:0]    inst_we_q, inst_we_d;
  logic [ROW_ADDR_W-1:0]  inst_addr_q, inst_addr_d;
  logic [ROW_W-1:0]       inst_data_q, inst_data_d;
  logic [LANES-1:0]       inst_lane_q, inst_lane_d;
  logic [NB_TILES-1:0]    const_we_q, const_we_d;
  logic [CONST_IDX_W-1:0] const_addr_q, const_addr_d;
  logic [WORD_W-1:0]      const_data_q, const_data_d;

  assign wtype         = word_type_e'(addr_i[TYPE_BIT]);
  assign word_mask     = addr_i[MASK_LSB +: NB_TILES];
  assign unused_idx_hi = ^addr_i[ADDR_W-1:IDX_LSB+CONST_IDX_W];
  assign is_inst       = wr_en_i && (wtype == WORD_INST);
  assign is_const      = wr_en_i && (wtype == WORD_CONST);
  assign push          = is_inst;
  assign tile_active   = (mask_q != '0);

  // A tile ends on an explicit flush, a constant word, or a tile switch.
  assign flush_evt = flush_i
                  || (is_const && tile_active)
                  || (is_inst && tile_active && (word_mask != mask_q));

  ipa_bit_gearbox #(
    .LANE_W (INST_W)
  ) u_gearbox (
    .Clk     (Clk),
    .Reset   (Reset),
    .push_i  (push),
    .word_i  (data_i),
    .flush_i (flush_evt),
    .emit_o  (g_emit),
    .row_o   (g_row),
    .lanes_o (g_lanes)
  );

  assign row_full = (row_q == RC_W'(ROW_DEPTH));
  assign write_ok = g_emit && !row_full;

  always_comb begin
    mask_d       = mask_q;
    row_d        = row_q;
    ovf_d        = ovf_q || (g_emit && row_full);
    exec_d       = flush_i;
    inst_we_d    = '0;
    inst_addr_d  = inst_addr_q;
    inst_data_d  = inst_data_q;
    inst_lane_d  = '0;
    const_we_d   = '0;
    const_addr_d = const_addr_q;
    const_data_d = const_data_q;

    if (flush_evt) begin
      row_d  = '0;
      mask_d = '0;
    end else if (write_ok) begin
      row_d  = row_q + RC_W'(1);
    end
    if (push) mask_d = word_mask;

    // Rows on a flush carry the outgoing tile's mask, captured before update.
    if (write_ok) begin
      inst_we_d   = mask_q;
      inst_addr_d = row_q[ROW_ADDR_W-1:0];
      inst_data_d = g_row;
      inst_lane_d = g_lanes;
    end

    if (is_const) begin
      const_we_d   = word_mask;
      const_addr_d = addr_i[IDX_LSB +: CONST_IDX_W];
      const_data_d = data_i;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      mask_q       <= '0;
      row_q        <= '0;
      ovf_q        <= 1'b0;
      exec_q       <= 1'b0;
      inst_we_q    <= '0;
      inst_addr_q  <= '0;
      inst_data_q  <= '0;
      inst_lane_q  <= '0;
      const_we_q   <= '0;
      const_addr_q <= '0;
      const_data_q <= '0;
    end else begin
      mask_q       <= mask_d;
      row_q        <= row_d;
      ovf_q        <= ovf_d;
      exec_q       <= exec_d;
      inst_we_q    <= inst_we_d;
      inst_addr_q  <= inst_addr_d;
      inst_data_q  <= inst_data_d;
      inst_lane_q  <= inst_lane_d;
      const_we_q   <= const_we_d;
      const_addr_q <= const_addr_d;
      const_data_q <= const_data_d;
    end
  end

  assign inst_we_o       = inst_we_q;
  assign inst_addr_o     = inst_addr_q;
  assign inst_data_o     = inst_data_q;
  assign inst_lane_vld_o = inst_lane_q;
  assign const_we_o      = const_we_q;
  assign const_addr_o    = const_addr_q;
  assign const_data_o    = const_data_q;
  assign ovf_o           = ovf_q;
  assign exec_en_o       = exec_q;

endmodule

// File: tb/tb_ipa_ctx_unpacker.sv
// Scoreboard bench for ipa_ctx_unpacker: a bit-queue model predicts rows and
// constant writes; a negedge monitor pops and compares them.
module tb_ipa_ctx_unpacker;

  localparam int ROW_DEPTH = 32;

  typedef struct {
    logic [15:0] we;
    logic [4:0]  addr;
    logic [79:0] data;
    logic [3:0]  lanes;
  } row_t;

  typedef struct {
    logic [15:0] we;
    logic [3:0]  addr;
    logic [63:0] data;
  } cst_t;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic        wr_en_i = 1'b0;
  logic [22:0] addr_i = '0;
  logic [63:0] data_i = '0;
  logic        flush_i = 1'b0;
  logic [15:0] inst_we_o;
  logic [4:0]  inst_addr_o;
  logic [79:0] inst_data_o;
  logic [3:0]  inst_lane_vld_o;
  logic [15:0] const_we_o;
  logic [3:0]  const_addr_o;
  logic [63:0] const_data_o;
  logic        ovf_o;
  logic        exec_en_o;

  ipa_ctx_unpacker #(.NB_TILES(16), .INST_W(20), .ROW_DEPTH(ROW_DEPTH)) dut (
    .Clk             (Clk),
    .Reset           (Reset),
    .wr_en_i         (wr_en_i),
    .addr_i          (addr_i),
    .data_i          (data_i),
    .flush_i         (flush_i),
    .inst_we_o       (inst_we_o),
    .inst_addr_o     (inst_addr_o),
    .inst_data_o     (inst_data_o),
    .inst_lane_vld_o (inst_lane_vld_o),
    .const_we_o      (const_we_o),
    .const_addr_o    (const_addr_o),
    .const_data_o    (const_data_o),
    .ovf_o           (ovf_o),
    .exec_en_o       (exec_en_o)
  );

  always #5 Clk = ~Clk;

  int   n_chk  = 0;
  int   n_fail = 0;
  row_t exp_rows[$];
  cst_t exp_csts[$];
  row_t obs[$];
  int   exec_pend = 0;
  int   csts_seen = 0;

  bit          mb[$];
  logic [15:0] m_mask = '0;
  int          m_row  = 0;
  bit          m_ovf  = 1'b0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic void m_emit(input logic [79:0] d, input logic [3:0] ln);
    row_t r;
    if (m_row == ROW_DEPTH) begin
      m_ovf = 1'b1;
    end else begin
      r.we = m_mask; r.addr = m_row[4:0]; r.data = d; r.lanes = ln;
      exp_rows.push_back(r);
      m_row++;
    end
  endfunction

  function automatic void m_flush();
    int n;
    logic [79:0] d;
    n = mb.size() / 20;
    if (n > 0) begin
      d = '0;
      for (int i = 0; i < n * 20; i++) d[i] = mb[i];
      m_emit(d, 4'((1 << n) - 1));
    end
    mb.delete();
    m_row  = 0;
    m_mask = '0;
  endfunction

  task automatic drive(input logic we, input logic [22:0] a, input logic [63:0] d, input logic fl);
    wr_en_i = we; addr_i = a; data_i = d; flush_i = fl;
    @(posedge Clk); #1;
    wr_en_i = 1'b0; addr_i = '0; data_i = '0; flush_i = 1'b0;
  endtask

  task automatic send_inst(input logic [15:0] mask, input logic [63:0] d);
    logic [79:0] row;
    if (m_mask != 0 && mask != m_mask) m_flush();
    for (int i = 0; i < 64; i++) mb.push_back(d[i]);
    m_mask = mask;
    if (mb.size() >= 80) begin
      for (int i = 0; i < 80; i++) row[i] = mb.pop_front();
      m_emit(row, 4'hF);
    end
    drive(1'b1, {6'd0, 1'b0, mask}, d, 1'b0);
  endtask

  task automatic send_const(input logic [15:0] mask, input logic [3:0] idx, input logic [63:0] d);
    cst_t c;
    m_flush();
    c.we = mask; c.addr = idx; c.data = d;
    exp_csts.push_back(c);
    drive(1'b1, {2'b00, idx, 1'b1, mask}, d, 1'b0);
  endtask

  task automatic send_flush();
    m_flush();
    exec_pend++;
    drive(1'b0, '0, '0, 1'b1);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge Clk); #1; end
  endtask

  // Monitor: pops one expectation per observed write, away from the active edge.
  always @(negedge Clk) begin : mon
    row_t r, a;
    cst_t c;
    logic [79:0] m;
    if (Reset) begin
      if (inst_we_o != 0) begin
        a.we = inst_we_o; a.addr = inst_addr_o; a.data = inst_data_o; a.lanes = inst_lane_vld_o;
        obs.push_back(a);
        if (exp_rows.size() == 0) begin
          chk("unexpected_row_we", {112'd0, inst_we_o}, 128'd0);
        end else begin
          r = exp_rows.pop_front();
          m = '0;
          for (int k = 0; k < 4; k++) if (r.lanes[k]) m[k*20 +: 20] = '1;
          chk("row_we", {112'd0, inst_we_o}, {112'd0, r.we});
          chk("row_addr", {123'd0, inst_addr_o}, {123'd0, r.addr});
          chk("row_lanes", {124'd0, inst_lane_vld_o}, {124'd0, r.lanes});
          chk("row_data", {48'd0, inst_data_o & m}, {48'd0, r.data & m});
        end
      end
      if (const_we_o != 0) begin
        csts_seen++;
        if (exp_csts.size() == 0) begin
          chk("unexpected_const_we", {112'd0, const_we_o}, 128'd0);
        end else begin
          c = exp_csts.pop_front();
          chk("const_we", {112'd0, const_we_o}, {112'd0, c.we});
          chk("const_addr", {124'd0, const_addr_o}, {124'd0, c.addr});
          chk("const_data", {64'd0, const_data_o}, {64'd0, c.data});
        end
      end
      if (exec_en_o) begin
        chk("exec_en_expected", {127'd0, exec_pend > 0}, 128'd1);
        if (exec_pend > 0) exec_pend--;
      end
    end
  end

  logic [63:0] w[5];
  logic [15:0] rmask[5];
  int          base;
  logic [15:0] cur;
  int          op;

  initial begin
    w[0] = 64'h0123_4567_89AB_CDEF;
    w[1] = 64'hFEDC_BA98_7654_3210;
    w[2] = 64'hA5A5_5A5A_C3C3_3C3C;
    w[3] = 64'h1111_2222_3333_4444;
    w[4] = 64'hDEAD_BEEF_CAFE_F00D;
    rmask[0] = 16'h0001; rmask[1] = 16'h0002; rmask[2] = 16'h0004;
    rmask[3] = 16'h0008; rmask[4] = 16'h8000;

    // Reset state
    repeat (3) @(posedge Clk);
    #2;
    chk("rst_inst_we", {112'd0, inst_we_o}, 128'd0);
    chk("rst_lane_vld", {124'd0, inst_lane_vld_o}, 128'd0);
    chk("rst_inst_data", {48'd0, inst_data_o}, 128'd0);
    chk("rst_const_we", {112'd0, const_we_o}, 128'd0);
    chk("rst_ovf", {127'd0, ovf_o}, 128'd0);
    chk("rst_exec_en", {127'd0, exec_en_o}, 128'd0);
    @(posedge Clk); #1;
    Reset = 1'b1;
    idle(1);

    // Tile 3: five words then flush, four full rows
    base = obs.size();
    for (int i = 0; i < 5; i++) send_inst(16'h0008, w[i]);
    send_flush();
    idle(3);
    chk("t1_rows", obs.size() - base, 4);
    chk("t1_row0_data", {48'd0, obs[base].data}, {48'd0, w[1][15:0], w[0]});
    chk("t1_row1_data", {48'd0, obs[base+1].data}, {48'd0, w[2][31:0], w[1][63:16]});
    chk("t1_row3_addr", {123'd0, obs[base+3].addr}, 128'd3);

    // Tile 0: two words then a constant at index 2
    base = obs.size();
    send_inst(16'h0001, w[0]);
    send_inst(16'h0001, w[1]);
    send_const(16'h0001, 4'd2, 64'h0000_1234_0000_5678);
    idle(3);
    chk("t2_rows", obs.size() - base, 2);
    chk("t2_flush_lanes", {124'd0, obs[base+1].lanes}, 128'h3);
    chk("t2_flush_addr", {123'd0, obs[base+1].addr}, 128'd1);
    chk("t2_consts", csts_seen, 1);

    // Mask change after three words
    base = obs.size();
    for (int i = 0; i < 3; i++) send_inst(16'h0001, w[i]);
    send_inst(16'h0002, w[3]);
    send_flush();
    idle(3);
    chk("t3_rows", obs.size() - base, 4);
    chk("t3_flush_we", {112'd0, obs[base+2].we}, 128'h1);
    chk("t3_flush_lanes", {124'd0, obs[base+2].lanes}, 128'h1);
    chk("t3_flush_addr", {123'd0, obs[base+2].addr}, 128'd2);
    chk("t3_new_we", {112'd0, obs[base+3].we}, 128'h2);
    chk("t3_new_addr", {123'd0, obs[base+3].addr}, 128'd0);

    // 33 full rows into one tile
    chk("t4_ovf_before", {127'd0, ovf_o}, 128'd0);
    base = obs.size();
    for (int i = 0; i < 42; i++) send_inst(16'h0010, {w[i % 5][31:0], 32'(i)});
    idle(2);
    chk("t4_rows", obs.size() - base, 32);
    chk("t4_last_addr", {123'd0, obs[obs.size()-1].addr}, 128'd31);
    chk("t4_ovf_set", {127'd0, ovf_o}, 128'd1);
    send_flush();
    idle(3);
    chk("t4_ovf_sticky", {127'd0, ovf_o}, 128'd1);
    chk("t4_rows_after_flush", obs.size() - base, 32);

    // Reset mid-load
    for (int i = 0; i < 3; i++) send_inst(16'h0004, w[i]);
    idle(1);
    Reset = 1'b0;
    #2;
    chk("t5_rst_ovf", {127'd0, ovf_o}, 128'd0);
    chk("t5_rst_exec", {127'd0, exec_en_o}, 128'd0);
    chk("t5_rst_we", {112'd0, inst_we_o}, 128'd0);
    mb.delete(); m_row = 0; m_mask = '0; m_ovf = 1'b0;
    idle(2);
    Reset = 1'b1;
    idle(1);
    base = obs.size();
    send_inst(16'h0004, w[3]);
    send_inst(16'h0004, w[4]);
    idle(2);
    chk("t5_rows", obs.size() - base, 1);
    chk("t5_restart_addr", {123'd0, obs[base].addr}, 128'd0);
    chk("t5_ovf_clear", {127'd0, ovf_o}, 128'd0);
    send_flush();
    idle(2);

    // Random bitstreams against the model
    cur = rmask[0];
    for (int i = 0; i < 300; i++) begin
      op = int'($urandom_range(0, 11));
      if (op <= 7) begin
        if ($urandom_range(0, 5) == 0) cur = rmask[$urandom_range(0, 4)];
        send_inst(cur, {$urandom, $urandom});
      end else if (op == 8) begin
        send_const(rmask[$urandom_range(0, 4)], 4'($urandom_range(0, 15)), {$urandom, $urandom});
      end else if (op == 9) begin
        send_flush();
      end else begin
        idle(1);
      end
    end
    send_flush();
    idle(4);

    chk("end_rows_drained", exp_rows.size(), 0);
    chk("end_consts_drained", exp_csts.size(), 0);
    chk("end_exec_drained", exec_pend, 0);
    chk("end_ovf", {127'd0, ovf_o}, {127'd0, m_ovf});

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ipa_ctx_unpacker.md
IPA_CTX_UNPACKER -- requirements
Module: ipa_ctx_unpacker

Interface
REQ-001 SHALL have parameter NB_TILES, default 16, number of CGRA tiles (NB_ROWS*NB_COLS).
REQ-002 SHALL have parameter INST_W, default 20, instruction width in bits.
REQ-003 SHALL have parameter ROW_DEPTH, default 32, instruction rows per tile; each row holds 4 instructions.
REQ-004 SHALL have port Clk, input, 1, clock; all state updates on rising edge.
REQ-005 SHALL have port Reset, input, 1, asynchronous, active-low reset.
REQ-006 SHALL have port wr_en_i, input, 1, valid for the context word; no backpressure.
REQ-007 SHALL have port addr_i, input, 23: [15:0] one-hot tile mask; [16] 0=instruction, 1=constant; [22:17] word index.
REQ-008 SHALL have port data_i, input, 64, context word.
REQ-009 SHALL have port flush_i, input, 1, end of load; connects to the DMA exec-enable strobe.
REQ-010 SHALL have port inst_we_o, output, NB_TILES, per-tile instruction row write enable.
REQ-011 SHALL have port inst_addr_o, output, 5, row index.
REQ-012 SHALL have port inst_data_o, output, 80, four packed instructions; lane k = bits [20k+19:20k].
REQ-013 SHALL have port inst_lane_vld_o, output, 4, per-lane valid.
REQ-014 SHALL have ports const_we_o (NB_TILES), const_addr_o (4) and const_data_o (64), outputs, for the constant write port; two 32-bit constants per word.
REQ-015 SHALL have port ovf_o, output, 1, sticky row-overflow error.
REQ-016 SHALL have port exec_en_o, output, 1, flush_i delayed until the final flush row is written.

Function
REQ-017 SHALL unpack the instruction bitstream LSB-first: bits [19:0] of the first instruction word of a tile are instruction 0.
REQ-018 SHALL keep a 144-bit accumulator and a 7-bit fill count (0..79 between words).
- Each accepted instruction word is appended at bit position fill.
REQ-019 SHALL emit a row when fill+64 >= 80.
- The row carries accumulator bits [79:0], all 4 lanes valid.
- The remaining bits shift down; fill becomes fill-16.
- Otherwise fill becomes fill+64.
REQ-020 SHALL register all write outputs: the row appears exactly 1 cycle after the completing word is accepted; at most one row per cycle.
REQ-021 SHALL track the current tile mask and row counter; the row counter starts at 0 per tile and increments per emitted row.
REQ-022 SHALL perform a flush on any of these events:
- (a) a constant word arrives after instruction words;
- (b) an instruction word arrives with a mask different from the current tile;
- (c) flush_i is asserted.
REQ-023 A flush SHALL emit a partial row if fill >= 20.
- lane_vld has floor(fill/20) low lanes set.
- Leftover bits fewer than 20 are discarded.
- Fill, row counter and mask tracking are then cleared.
REQ-024 On event (b), the flush row SHALL use the old mask; the new word then starts a fresh accumulator in the same cycle.
REQ-025 SHALL write a constant word 1 cycle after acceptance:
- const_we_o = mask;
- const_addr_o = addr_i[20:17];
- const_data_o = data_i.
- This is independent of and concurrent with instruction writes.
REQ-026 SHALL raise ovf_o and suppress the write when a row would be emitted with row counter = ROW_DEPTH; ovf_o stays set until Reset.
REQ-027 SHALL assert exec_en_o for 1 cycle, 1 cycle after flush_i; any flush row is written in that same cycle.
REQ-028 SHALL hold all write enables at 0 in cycles with no emission; wr_en_i=0 SHALL leave the accumulator unchanged.

Reset
REQ-029 On Reset low, all outputs SHALL be 0, including ovf_o and exec_en_o.
REQ-030 On Reset low, fill, row counter, tile mask and accumulator SHALL be 0.
REQ-031 Reset asserted mid-load SHALL discard buffered bits without emitting a row.

Structure
REQ-032 A shared package ipa_ctx_pkg SHALL hold INST_W, LANES=4, ROW_W=80, the address-field bit positions and the word-type enum.
REQ-033 The 144-bit gearbox (append, emit, shift) SHALL be one sub-module, ipa_bit_gearbox; tile tracking, flush and constant path stay in the top.

Verification
REQ-034 Tile 3, 5 instruction words (0x...), then flush_i -> rows 0..3 with 4 lanes valid on inst_we_o=0x0008.
- Flush row 4 has lane_vld=0x0, so no write.
- Totals: 320 bits, 16 instructions.
REQ-035 Tile 0, 2 instruction words then a constant word at index 2 -> row 0 (4 lanes), then flush row 1 with lane_vld=0x3.
- Same cycle: const_we_o=0x0001, const_addr_o=2.
REQ-036 Mask change 0x0001->0x0002 mid-stream after 3 words -> flush row 2 with lane_vld=0x1 to tile 0; the new word starts tile 1 at row 0.
REQ-037 33 full rows to one tile -> rows 0..31 written; the 33rd is suppressed; ovf_o=1 until Reset.
REQ-038 Reset asserted after 3 words -> no further writes; ovf_o=0 and exec_en_o=0; the next load starts at row 0.
REQ-039 Random bitstreams vs. a scoreboard model -> every complete 20-bit instruction lands in the correct tile, row and lane.
